// File: rtl/pstage_pkg.sv
// Shared definitions for the pipeline-stage registers: state encoding,
// lane indices of the D/E, E/M and M/W boundaries, and reset-image construction.
package pstage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pstage_state_e;

    localparam int unsigned LN_INSTR = 0;
    localparam int unsigned LN_PC4   = 1;
    localparam int unsigned LN_ALU   = 2;
    localparam int unsigned LN_RTD   = 3;
    localparam int unsigned LN_CMP   = 4;

    // Widest stage image the helper can build; callers slice off what they need.
    localparam int unsigned IMG_W = 4096;

    // All-zero image with one lane carrying val, truncated or zero-extended to dw.
    function automatic logic [IMG_W-1:0] lane_image(input int unsigned dw,
                                                    input int unsigned lane,
                                                    input logic [63:0] val);
        logic [63:0] v;
        if (dw >= 64) begin
            v = val;
        end else begin
            v = val & ((64'd1 << dw) - 64'd1);
        end
        return IMG_W'(v) << (lane * dw);
    endfunction

endpackage

// File: rtl/pstage_slot.sv
// One NL*DW storage slot of a pipeline stage; clear wins over load.
module pstage_slot #(
    parameter int unsigned         W       = 160,
    parameter logic [W-1:0]        RST_IMG = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] dat_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Slot storage with asynchronous reset to the stage's reset image.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= RST_IMG;
        end else if (clear_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= dat_i;
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pstage_reg.sv
// Pipeline-stage register: NL lanes of DW bits with valid/ready handshake,
// optional two-entry skid buffer (registered ready), flush and a PC lane reset value.
module pstage_reg
    import pstage_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned NL          = 5,
    parameter int unsigned PC_LANE     = 1,
    parameter logic [31:0] PC_RST      = 32'h0000_3000,
    parameter bit          SKID        = 1'b1,
    parameter bit          BUBBLE_ZERO = 1'b1
) (
    input  logic             pstage_clk_i,
    input  logic             pstage_rst_i,
    input  logic             pstage_flush_i,
    input  logic             pstage_vld_i,
    output logic             pstage_rdy_o,
    input  logic [NL*DW-1:0] pstage_dat_i,
    output logic             pstage_vld_o,
    input  logic             pstage_rdy_i,
    output logic [NL*DW-1:0] pstage_dat_o,
    output logic [1:0]       pstage_cnt_o
);

    localparam int unsigned      W        = NL * DW;
    localparam logic [IMG_W-1:0] IMG_FULL = lane_image(DW, PC_LANE, {32'h0, PC_RST});
    localparam logic [W-1:0]     RST_IMG  = IMG_FULL[W-1:0];

    pstage_state_e state_q, state_d;
    logic          rdy_q, rdy_d;
    logic          in_fire_s, out_fire_s;
    logic          m_load_s, m_clr_s, m_from_s_s, s_load_s, s_clr_s;
    logic [W-1:0]  m_q, s_q, m_in_s;

    assign pstage_vld_o = (state_q != EMPTY);
    assign pstage_cnt_o = state_q;
    // Skid mode hides downstream ready behind a register; single-entry mode passes it through.
    assign pstage_rdy_o = SKID ? rdy_q : (~pstage_vld_o | pstage_rdy_i);
    assign in_fire_s    = pstage_vld_i & pstage_rdy_o;
    assign out_fire_s   = pstage_vld_o & pstage_rdy_i;
    assign m_in_s       = m_from_s_s ? s_q : pstage_dat_i;
    assign rdy_d        = (state_d != TWO);

    // Next-state and slot-control decode.
    always_comb begin
        state_d    = state_q;
        m_load_s   = 1'b0;
        m_clr_s    = 1'b0;
        m_from_s_s = 1'b0;
        s_load_s   = 1'b0;
        s_clr_s    = 1'b0;
        if (pstage_flush_i) begin
            state_d = EMPTY;
            m_clr_s = 1'b1;
            s_clr_s = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        m_load_s = 1'b1;
                        state_d  = ONE;
                    end else begin
                        state_d  = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        m_load_s = 1'b1;
                    end else if (in_fire_s && SKID) begin
                        s_load_s = 1'b1;
                        state_d  = TWO;
                    end else if (out_fire_s) begin
                        m_clr_s  = BUBBLE_ZERO;
                        state_d  = EMPTY;
                    end else begin
                        state_d  = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        m_load_s   = 1'b1;
                        m_from_s_s = 1'b1;
                        state_d    = ONE;
                    end else begin
                        state_d    = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    m_clr_s = 1'b1;
                    s_clr_s = 1'b1;
                end
            endcase
        end
    end

    // State and registered upstream ready.
    always_ff @(posedge pstage_clk_i or posedge pstage_rst_i) begin
        if (pstage_rst_i) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    pstage_slot #(.W(W), .RST_IMG(RST_IMG)) u_main (
        .clk_i   (pstage_clk_i),
        .rst_i   (pstage_rst_i),
        .load_i  (m_load_s),
        .clear_i (m_clr_s),
        .dat_i   (m_in_s),
        .q_o     (m_q)
    );

    pstage_slot #(.W(W), .RST_IMG(RST_IMG)) u_skid (
        .clk_i   (pstage_clk_i),
        .rst_i   (pstage_rst_i),
        .load_i  (s_load_s),
        .clear_i (s_clr_s),
        .dat_i   (pstage_dat_i),
        .q_o     (s_q)
    );

    assign pstage_dat_o = m_q;

endmodule

// File: tb/tb_pstage_reg.sv
// Bench for pstage_reg: a skid instance and a single-entry instance, with a
// scoreboard queue per instance checking FIFO order of everything emitted.
module tb_pstage_reg;

    localparam logic [159:0] RST_IMG = {32'h0, 32'h0, 32'h0, 32'h0000_3000, 32'h0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         vld_i = 1'b0, rdy_i = 1'b0;
    logic         b_vld_i = 1'b0, b_rdy_i = 1'b0;
    logic [159:0] dat_i = '0;
    logic         a_rdy_o, a_vld_o, b_rdy_o, b_vld_o;
    logic [159:0] a_dat_o, b_dat_o;
    logic [1:0]   a_cnt_o, b_cnt_o;

    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    logic [159:0] sb_a[$];
    logic [159:0] sb_b[$];
    logic [159:0] exp_a, exp_b, w_a, w_b, w_c, w_d, w_e;

    always #5 clk = ~clk;

    pstage_reg #(.SKID(1'b1)) dut_a (
        .pstage_clk_i(clk), .pstage_rst_i(rst), .pstage_flush_i(flush),
        .pstage_vld_i(vld_i), .pstage_rdy_o(a_rdy_o), .pstage_dat_i(dat_i),
        .pstage_vld_o(a_vld_o), .pstage_rdy_i(rdy_i), .pstage_dat_o(a_dat_o),
        .pstage_cnt_o(a_cnt_o)
    );

    pstage_reg #(.SKID(1'b0)) dut_b (
        .pstage_clk_i(clk), .pstage_rst_i(rst), .pstage_flush_i(flush),
        .pstage_vld_i(b_vld_i), .pstage_rdy_o(b_rdy_o), .pstage_dat_i(dat_i),
        .pstage_vld_o(b_vld_o), .pstage_rdy_i(b_rdy_i), .pstage_dat_o(b_dat_o),
        .pstage_cnt_o(b_cnt_o)
    );

    function automatic logic [159:0] rnd160();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: just before each edge, pop/compare on out_fire, push on in_fire.
    always @(posedge clk) begin
        #7;
        if (!rst) begin
            if (a_vld_o && rdy_i) begin
                n_checks++;
                if (sb_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a: unexpected output %h, expected none", a_dat_o);
                end else begin
                    exp_a = sb_a.pop_front();
                    if (a_dat_o !== exp_a) begin
                        n_fail++;
                        $display("FAIL sb_a: got %h expected %h", a_dat_o, exp_a);
                    end
                end
            end
            if (vld_i && a_rdy_o && !flush) sb_a.push_back(dat_i);
            if (b_vld_o && b_rdy_i) begin
                n_checks++;
                if (sb_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b: unexpected output %h, expected none", b_dat_o);
                end else begin
                    exp_b = sb_b.pop_front();
                    if (b_dat_o !== exp_b) begin
                        n_fail++;
                        $display("FAIL sb_b: got %h expected %h", b_dat_o, exp_b);
                    end
                end
            end
            if (b_vld_i && b_rdy_o && !flush) sb_b.push_back(dat_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #3;
        n_checks++;
        if (a_dat_o !== RST_IMG) begin n_fail++; $display("FAIL reset_dat: got %h expected %h", a_dat_o, RST_IMG); end
        n_checks++;
        if ({a_vld_o, a_rdy_o, a_cnt_o} !== 4'b0100) begin n_fail++; $display("FAIL reset_ctl: got vld/rdy/cnt %b expected 0100", {a_vld_o, a_rdy_o, a_cnt_o}); end
        n_checks++;
        if (b_dat_o !== RST_IMG || b_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_b: got %h rdy %b", b_dat_o, b_rdy_o); end
        tick();
    endtask

    task automatic test_stream();
        rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat_i = rnd160();
            vld_i = 1'b1;
            tick();
            #3;
            n_checks++;
            if (a_cnt_o !== 2'd1 || a_rdy_o !== 1'b1 || a_vld_o !== 1'b1) begin
                n_fail++; $display("FAIL stream_%0d: got cnt %0d rdy %b vld %b expected 1 1 1", i, a_cnt_o, a_rdy_o, a_vld_o);
            end
        end
        vld_i = 1'b0;
        tick();
        #3;
        n_checks++;
        if (a_cnt_o !== 2'd0 || a_dat_o !== '0) begin n_fail++; $display("FAIL stream_bubble: got cnt %0d dat %h expected 0 and zero", a_cnt_o, a_dat_o); end
    endtask

    task automatic test_stall_fill();
        w_a = rnd160(); w_b = rnd160();
        tick();
        dat_i = w_a; vld_i = 1'b1; rdy_i = 1'b1;
        tick();
        rdy_i = 1'b0; dat_i = w_b;
        #3;
        n_checks++;
        if (a_rdy_o !== 1'b1) begin n_fail++; $display("FAIL stall_rdy_one: got %b expected 1", a_rdy_o); end
        tick();
        vld_i = 1'b0;
        #3;
        n_checks++;
        if (a_cnt_o !== 2'd2 || a_rdy_o !== 1'b0 || a_dat_o !== w_a) begin
            n_fail++; $display("FAIL stall_two: got cnt %0d rdy %b dat %h expected 2 0 %h", a_cnt_o, a_rdy_o, a_dat_o, w_a);
        end
        repeat (3) tick();
        #3;
        n_checks++;
        if (a_cnt_o !== 2'd2 || a_dat_o !== w_a) begin n_fail++; $display("FAIL stall_hold: got cnt %0d dat %h expected 2 %h", a_cnt_o, a_dat_o, w_a); end
        tick();
        rdy_i = 1'b1;
        tick();
        #3;
        n_checks++;
        if (a_cnt_o !== 2'd1 || a_dat_o !== w_b) begin n_fail++; $display("FAIL stall_release: got cnt %0d dat %h expected 1 %h", a_cnt_o, a_dat_o, w_b); end
        tick();
        #3;
        n_checks++;
        if (a_cnt_o !== 2'd0) begin n_fail++; $display("FAIL stall_drain: got cnt %0d expected 0", a_cnt_o); end
    endtask

    task automatic test_flush();
        w_a = rnd160(); w_b = rnd160(); w_c = rnd160(); w_d = rnd160(); w_e = rnd160();
        tick();
        dat_i = w_a; vld_i = 1'b1; rdy_i = 1'b1;
        tick();
        dat_i = w_b; rdy_i = 1'b0;
        tick();
        dat_i = w_c; flush = 1'b1;
        tick();
        flush = 1'b0; vld_i = 1'b0;
        sb_a.delete();
        #3;
        n_checks++;
        if (a_vld_o !== 1'b0 || a_cnt_o !== 2'd0 || a_rdy_o !== 1'b1 || a_dat_o !== '0) begin
            n_fail++; $display("FAIL flush_two: got vld %b cnt %0d rdy %b dat %h", a_vld_o, a_cnt_o, a_rdy_o, a_dat_o);
        end
        tick();
        rdy_i = 1'b1;
        repeat (3) tick();
        dat_i = w_d; vld_i = 1'b1;
        tick();
        dat_i = w_e; flush = 1'b1;
        tick();
        flush = 1'b0; vld_i = 1'b0;
        #3;
        n_checks++;
        if (a_vld_o !== 1'b0 || a_cnt_o !== 2'd0 || a_dat_o !== '0) begin
            n_fail++; $display("FAIL flush_one: got vld %b cnt %0d dat %h", a_vld_o, a_cnt_o, a_dat_o);
        end
        repeat (2) tick();
    endtask

    task automatic test_async_reset();
        dat_i = rnd160(); vld_i = 1'b1; rdy_i = 1'b0;
        tick();
        dat_i = rnd160();
        tick();
        vld_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_dat_o !== RST_IMG || a_vld_o !== 1'b0 || a_cnt_o !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: got vld %b cnt %0d dat %h expected reset image", a_vld_o, a_cnt_o, a_dat_o);
        end
        sb_a.delete();
        tick();
        rst = 1'b0; rdy_i = 1'b1;
        #3;
        n_checks++;
        if (a_rdy_o !== 1'b1 || a_cnt_o !== 2'd0) begin n_fail++; $display("FAIL async_release: got rdy %b cnt %0d", a_rdy_o, a_cnt_o); end
        tick();
    endtask

    task automatic test_skid0();
        w_a = rnd160(); w_b = rnd160();
        dat_i = w_a; b_vld_i = 1'b1; b_rdy_i = 1'b1;
        tick();
        b_rdy_i = 1'b0; dat_i = w_b;
        #1;
        n_checks++;
        if (b_rdy_o !== 1'b0) begin n_fail++; $display("FAIL skid0_rdy_comb: got %b expected 0", b_rdy_o); end
        tick();
        #3;
        n_checks++;
        if (b_dat_o !== w_a || b_cnt_o !== 2'd1) begin n_fail++; $display("FAIL skid0_hold: got cnt %0d dat %h expected 1 %h", b_cnt_o, b_dat_o, w_a); end
        tick();
        b_rdy_i = 1'b1;
        #1;
        n_checks++;
        if (b_rdy_o !== 1'b1) begin n_fail++; $display("FAIL skid0_rdy_up: got %b expected 1", b_rdy_o); end
        tick();
        b_vld_i = 1'b0;
        #3;
        n_checks++;
        if (b_cnt_o !== 2'd1 || b_dat_o !== w_b) begin n_fail++; $display("FAIL skid0_passthru: got cnt %0d dat %h expected 1 %h", b_cnt_o, b_dat_o, w_b); end
        tick();
        #3;
        n_checks++;
        if (b_cnt_o !== 2'd0 || b_dat_o !== '0) begin n_fail++; $display("FAIL skid0_drain: got cnt %0d dat %h", b_cnt_o, b_dat_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            dat_i   = rnd160();
            vld_i   = 1'($urandom_range(0, 3) != 0);
            rdy_i   = 1'($urandom_range(0, 2) != 0);
            b_vld_i = 1'($urandom_range(0, 3) != 0);
            b_rdy_i = 1'($urandom_range(0, 2) != 0);
            #3;
            n_checks++;
            if (a_cnt_o > 2'd2 || b_cnt_o > 2'd1) begin n_fail++; $display("FAIL b2b_cnt: got a %0d b %0d", a_cnt_o, b_cnt_o); end
            tick();
        end
        vld_i = 1'b0; b_vld_i = 1'b0; rdy_i = 1'b1; b_rdy_i = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d/%0d pending expected 0/0", sb_a.size(), sb_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush();
        test_async_reset();
        test_skid0();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
